// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: store-path fed 8N1 UART transmitter
// small power-of-two FIFO ahead of an LSB-first serialiser
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_overflow,
  output logic       TXD,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [7:0]    mem [FIFO_DEPTH];

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic [7:0]    shift_n;
  logic          txd_q;
  logic          txd_n;
  logic          ovf_q;
  logic          pop;
  logic          push;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // a pop frees the slot the write lands in, so full+pop still accepts
  assign push     = wr_en && (!full || pop);
  assign busy     = (state != IDLE) || !empty;
  assign TXD      = txd_q;
  assign overflow = ovf_q;

  // frame sequencer: next state, baud count, bit index and shifter
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_n = mem[rptr[AW-1:0]];
          cnt_n   = CNT_MAX;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = CNT_MAX;
          idx_n   = 3'd0;
          state_n = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shift_n = {1'b0, shift[7:1]};
          cnt_n   = CNT_MAX;
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        if (cnt == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = mem[rptr[AW-1:0]];
            cnt_n   = CNT_MAX;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
    endcase
  end

  // line level decoded from the upcoming state so TXD is a clean flop
  always_comb begin
    txd_n = 1'b1;
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset, pointers gate validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= wr_data;
    end
  end

  // pointers, sticky overflow, sequencer state and line register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      ovf_q <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'd0;
      txd_q <= 1'b1;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      if (wr_en && !push) begin
        ovf_q <= 1'b1;
      end else if (clr_overflow) begin
        ovf_q <= 1'b0;
      end
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      txd_q <= txd_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table plus serial-line scoreboard
// CLKS_PER_BIT=4, FIFO_DEPTH=4
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_overflow;
  logic       txd;
  logic       busy;
  logic       full;
  logic       empty;
  logic       overflow;

  int n_checks;
  int n_fail;
  int cyc;

  logic [7:0] exp_q [$];
  int         starts [$];

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic       acc;
    logic       x_full;
    logic       x_empty;
    logic       x_ovf;
    logic       x_busy;
  } vec_t;

  vec_t vt [10];

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .clr_overflow(clr_overflow),
    .TXD(txd),
    .busy(busy),
    .full(full),
    .empty(empty),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // inputs applied at a negedge, return at the negedge after capture
  task automatic step(input logic w, input logic [7:0] d,
                      input logic c);
    wr_en        = w;
    wr_data      = d;
    clr_overflow = c;
    @(negedge clk);
    wr_en        = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    chk("sb_drain", exp_q.size(), 0);
  endtask

  // serial receiver: decodes frames and pops the scoreboard
  logic [7:0] mon_b;
  logic       mon_ab;
  logic       mon_bad;
  always begin
    @(negedge clk);
    if (resetn && txd === 1'b0) begin
      starts.push_back(cyc);
      mon_ab  = 1'b0;
      mon_bad = 1'b0;
      mon_b   = 8'd0;
      for (int j = 1; j < FRAME; j++) begin
        @(negedge clk);
        if (!resetn) begin
          mon_ab = 1'b1;
          break;
        end
        if (j < CPB && txd !== 1'b0) mon_bad = 1'b1;
        if (j >= CPB && j < 9 * CPB && (j % CPB) == CPB / 2)
          mon_b[j / CPB - 1] = txd;
        if (j >= 9 * CPB && txd !== 1'b1) mon_bad = 1'b1;
      end
      if (!mon_ab) begin
        chk("rx_frame", {63'd0, mon_bad}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", {56'd0, mon_b}, 64'hffff);
        end else begin
          chk("rx_byte", {56'd0, mon_b}, {56'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [39:0] wave;
    logic [39:0] xwave;
    logic [9:0]  fr;
    int          n;
    int          bad;

    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    wr_en        = 1'b0;
    wr_data      = 8'd0;
    clr_overflow = 1'b0;
    resetn       = 1'b1;

    vt[0] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b1, 8'hff, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 8'h0f, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 8'h3c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    #1 resetn = 1'b0;
    #1;
    chk("rst_txd", {63'd0, txd}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // single byte waveform
    exp_q.push_back(8'ha5);
    step(1'b1, 8'ha5, 1'b0);
    chk("a5_empty", {63'd0, empty}, 64'd0);
    fr = {1'b1, 8'ha5, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      wave[i]  = txd;
      xwave[i] = fr[i / CPB];
    end
    chk("a5_wave", {24'd0, wave}, {24'd0, xwave});
    chk("a5_busy_k40", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("a5_busy_k41", {63'd0, busy}, 64'd0);
    wait_idle(10);

    // burst, overflow and clear via vector table
    starts.delete();
    for (int i = 0; i < 10; i++) begin
      if (vt[i].acc) exp_q.push_back(vt[i].data);
      step(vt[i].wr, vt[i].data, vt[i].clr);
      chk($sformatf("vec%0d_full", i), {63'd0, full},
          {63'd0, vt[i].x_full});
      chk($sformatf("vec%0d_empty", i), {63'd0, empty},
          {63'd0, vt[i].x_empty});
      chk($sformatf("vec%0d_ovf", i), {63'd0, overflow},
          {63'd0, vt[i].x_ovf});
      chk($sformatf("vec%0d_busy", i), {63'd0, busy},
          {63'd0, vt[i].x_busy});
    end
    wait_idle(6 * FRAME);
    chk("burst_frames", starts.size(), 5);
    bad = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != FRAME) bad++;
    chk("burst_gaps", bad, 0);

    // full with a simultaneous pop on the stop-end edge
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h11 * (i + 1)));
      step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
    end
    chk("fp_full_e4", {63'd0, full}, 64'd1);
    for (int i = 5; i < 41; i++) step(1'b0, 8'd0, 1'b0);
    chk("fp_full_e40", {63'd0, full}, 64'd1);
    exp_q.push_back(8'h99);
    step(1'b1, 8'h99, 1'b0);
    chk("fp_full_e41", {63'd0, full}, 64'd1);
    chk("fp_ovf_e41", {63'd0, overflow}, 64'd0);
    wait_idle(7 * FRAME);

    // pointer wrap: 20 bytes with full polling
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (full && n < 2 * FRAME) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2 * FRAME) chk("wrap_poll", n, 0);
      exp_q.push_back(8'(i));
      step(1'b1, 8'(i), 1'b0);
    end
    wait_idle(8 * FRAME);
    chk("wrap_empty", {63'd0, empty}, 64'd1);
    chk("wrap_ovf", {63'd0, overflow}, 64'd0);

    // reset in the middle of data bit 3
    @(negedge clk);
    step(1'b1, 8'hf0, 1'b0);
    repeat (18) @(negedge clk);
    chk("mid_txd_pre", {63'd0, txd}, 64'd0);
    #1 resetn = 1'b0;
    #1;
    chk("mid_txd", {63'd0, txd}, 64'd1);
    chk("mid_empty", {63'd0, empty}, 64'd1);
    chk("mid_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h81);
    step(1'b1, 8'h81, 1'b0);
    wait_idle(2 * FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
